// File: rtl/serial_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : serial_adder_pkg                                            |
// | Brief   : Shared types and helpers for the bit-serial adder: carry    |
// |           state enum, counter width function, full-adder functions.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package serial_adder_pkg;

   // Carry state: S0 means carry 0, S1 means carry 1.
   typedef enum logic {
      S0 = 1'b0,
      S1 = 1'b1
   } state_t;

   // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return w;
   endfunction

   // Full-adder sum bit.
   function automatic logic fa_sum(input logic a, input logic b, input logic cin);
      return a ^ b ^ cin;
   endfunction

   // Full-adder carry-out: majority of the three inputs.
   function automatic logic fa_carry(input logic a, input logic b, input logic cin);
      return (a & b) | (a & cin) | (b & cin);
   endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/full_adder_bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : full_adder_bit                                              |
// | Brief   : One-bit full adder used as the serial adder's datapath.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   import serial_adder_pkg::*;

   assign s    = fa_sum(a, b, cin);
   assign cout = fa_carry(a, b, cin);

endmodule : full_adder_bit
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : serial_adder                                                |
// | Brief   : LSB-first bit-serial adder with a one-bit carry state and   |
// |           optional word framing (FRAME_LEN > 0 clears the carry on    |
// |           the last bit of each word and pulses DONE).                 |
// |           Define SERIAL_ADDER_REGOUT_EN to register Z and DONE        |
// |           (one cycle latency); otherwise they are combinational.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module serial_adder #(
   parameter int FRAME_LEN = 0
) (
   input  logic CLK,
   input  logic RESET_N,
   input  logic X,
   input  logic Y,
   output logic Z,
   output logic CARRY,
   output logic DONE
);
   import serial_adder_pkg::*;

   state_t r_state;
   state_t w_state_next;
   logic   w_carry;
   logic   w_sum;
   logic   w_cout;
   logic   w_last;

   assign w_carry = (r_state == S1);

   full_adder_bit u_fa (
      .a    (X),
      .b    (Y),
      .cin  (w_carry),
      .s    (w_sum),
      .cout (w_cout)
   );

   generate
      if (FRAME_LEN > 0) begin : g_framed
         // A one-bit counter is kept for FRAME_LEN = 1 so the compare is legal.
         localparam int              CNT_W  = (FRAME_LEN > 1) ? clog2(FRAME_LEN) : 1;
         localparam logic [CNT_W-1:0] C_LAST = CNT_W'(FRAME_LEN - 1);

         logic [CNT_W-1:0] r_cnt;

         // Bit position within the current word, wrapping after the last bit.
         always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
               r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         assign w_last = (r_cnt == C_LAST);
      end else begin : g_unframed
         assign w_last = 1'b0;
      end
   endgenerate

   // Carry state register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= S0;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next carry: the full-adder carry-out, forced to S0 on a word's last bit.
   always_comb begin
      w_state_next = r_state;
      if (w_last) begin
         w_state_next = S0;
      end else if (w_cout) begin
         w_state_next = S1;
      end else begin
         w_state_next = S0;
      end
   end

   assign CARRY = w_carry;

`ifdef SERIAL_ADDER_REGOUT_EN
   logic r_z;
   logic r_done;

   // Registered sum and frame marker, kept aligned with each other.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_z    <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_z    <= w_sum;
         r_done <= w_last;
      end
   end

   assign Z    = r_z;
   assign DONE = r_done;
`else
   assign Z    = w_sum;
   assign DONE = w_last;
`endif

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module  : tb_serial_adder                                             |
// | Brief   : Self-checking bench: an unframed and a 4-bit framed adder   |
// |           driven with the same bit streams, compared against an       |
// |           arithmetic reference model.                                 |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_serial_adder;

   localparam int FL = 4;

   logic clk;
   logic rst_n;
   logic x;
   logic y;
   logic z_u, carry_u, done_u;
   logic z_f, carry_f, done_f;

   int n_checks;
   int n_errors;

   // Reference model state
   int mc_u;    // unframed carry
   int idx_f;   // bit index in current frame
   int xw_f;    // operand A bits collected so far in frame
   int yw_f;    // operand B bits collected so far in frame

   serial_adder #(.FRAME_LEN(0)) dut_u (
      .CLK(clk), .RESET_N(rst_n), .X(x), .Y(y),
      .Z(z_u), .CARRY(carry_u), .DONE(done_u)
   );

   serial_adder #(.FRAME_LEN(FL)) dut_f (
      .CLK(clk), .RESET_N(rst_n), .X(x), .Y(y),
      .Z(z_f), .CARRY(carry_f), .DONE(done_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_bit(input string tag, input logic got, input logic exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mc_u  = 0;
      idx_f = 0;
      xw_f  = 0;
      yw_f  = 0;
   endtask

   // Checks made while reset is held low.
   task automatic check_in_reset();
      check_bit("rst_carry_u", carry_u, 1'b0);
      check_bit("rst_carry_f", carry_f, 1'b0);
      check_bit("rst_done_u", done_u, 1'b0);
      check_bit("rst_done_f", done_f, 1'b0);
`ifdef SERIAL_ADDER_REGOUT_EN
      check_bit("rst_z_u", z_u, 1'b0);
      check_bit("rst_z_f", z_f, 1'b0);
`else
      check_bit("rst_z_u", z_u, x ^ y);
      check_bit("rst_z_f", z_f, x ^ y);
`endif
   endtask

   // Long reset with X=Y=1, released right at a falling edge.
   task automatic apply_reset();
      rst_n = 1'b0;
      x = 1'b1;
      y = 1'b1;
      #12;
      check_in_reset();
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // Short asynchronous pulse between edges; called just after a falling edge.
   task automatic pulse_reset();
      #0.5;
      rst_n = 1'b0;
      #1;
      check_in_reset();
      #2;
      rst_n = 1'b1;
      model_reset();
   endtask

   // Drive one bit pair, check outputs, cross one rising edge, check state.
   task automatic step(input logic xi, input logic yi);
      int   s_u, tot;
      logic ez_u, ec_u, ez_f, ec_f, ed_f;
      x = xi;
      y = yi;
      s_u  = int'(xi) + int'(yi) + mc_u;
      ez_u = s_u[0];
      ec_u = s_u[1];
      xw_f = xw_f | (int'(xi) << idx_f);
      yw_f = yw_f | (int'(yi) << idx_f);
      tot  = xw_f + yw_f;
      ez_f = tot[idx_f];
      ed_f = (idx_f == FL - 1);
      ec_f = ed_f ? 1'b0 : tot[idx_f + 1];
      #1;
`ifndef SERIAL_ADDER_REGOUT_EN
      check_bit("z_u", z_u, ez_u);
      check_bit("z_f", z_f, ez_f);
      check_bit("done_f", done_f, ed_f);
      check_bit("done_u", done_u, 1'b0);
`endif
      @(posedge clk);
      #1;
      mc_u = int'(ec_u);
      if (ed_f) begin
         idx_f = 0;
         xw_f  = 0;
         yw_f  = 0;
      end else begin
         idx_f = idx_f + 1;
      end
      check_bit("carry_u", carry_u, ec_u);
      check_bit("carry_f", carry_f, ec_f);
`ifdef SERIAL_ADDER_REGOUT_EN
      check_bit("z_u", z_u, ez_u);
      check_bit("z_f", z_f, ez_f);
      check_bit("done_f", done_f, ed_f);
      check_bit("done_u", done_u, 1'b0);
`endif
      @(negedge clk);
   endtask

   initial begin
      logic [1:0] xy;
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      x = 1'b0;
      y = 1'b0;
      model_reset();

      // Reset behaviour and the reference unframed sequence.
      apply_reset();
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);

      // Framed words: 0xF + 0x1 then 0x1 + 0x1.
      apply_reset();
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      // Asynchronous reset mid-stream with carry set and counter mid-frame.
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      check_bit("pre_pulse_carry_u", carry_u, 1'b1);
      pulse_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1);
      end

      // Exhaustive: every (X, Y) from carry 0 and from carry 1.
      for (int c = 0; c < 2; c++) begin
         for (int v = 0; v < 4; v++) begin
            xy = v[1:0];
            step(1'b0, 1'b0);
            pulse_reset();
            if (c == 1) begin
               step(1'b1, 1'b1);
            end
            step(xy[1], xy[0]);
         end
      end

      // Random streams with occasional asynchronous resets.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            pulse_reset();
         end
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_serial_adder
`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder: adds two LSB-first operand streams one bit per clock and emits the sum stream LSB-first, keeping the carry in a one-bit state register between cycles. It is a datapath leaf in the serial arithmetic path, fed by shift registers or serial links, with optional framing that clears the carry at word boundaries.

## Interface
- FRAME_LEN, default 0: bits per word. 0 means unframed (carry never auto-cleared). Legal range 0..65535.
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  asynchronous, active-low reset.
- X  input  1  operand A bit, LSB first.
- Y  input  1  operand B bit, LSB first.
- Z  output  1  sum bit.
- CARRY  output  1  current carry state register.
- DONE  output  1  one-cycle pulse on the last bit of a frame. Constant 0 when FRAME_LEN = 0.
- Port order is fixed: CLK, RESET_N, X, Y, Z, CARRY, DONE. Positional instantiation using only the first five ports is legal.

## Operation
- State machine with two states: S0 (carry 0) and S1 (carry 1). Reset enters S0.
- Sum: Z = X ^ Y ^ C.
- Next carry: C_next = majority(X, Y, C).
- Transitions:
  - S0 to S1 when X&Y.
  - S1 to S0 when !X&!Y.
  - Otherwise the state holds.
- Framing (FRAME_LEN > 0):
  - A bit counter counts 0..FRAME_LEN-1 and wraps.
  - On the edge that consumes bit FRAME_LEN-1, the carry is loaded with 0 instead of C_next. The final carry-out is discarded (modulo 2^FRAME_LEN).
  - DONE = 1 while the counter equals FRAME_LEN-1.
  - FRAME_LEN = 1 gives a plain XOR with DONE always high.
- Reset mid-operation: carry, counter and the registered Z all go to 0 immediately (asynchronous). The first edge after RESET_N rises treats the current bits as bit 0 with carry 0.
- X and Y have no valid qualifier; every clock edge consumes one bit pair.

## Timing
- Default (combinational) output:
  - Z is a Mealy output, valid in the same cycle as X/Y.
  - Zero latency.
  - Z is combinational from X, Y and the carry register.
- CARRY changes only on the rising CLK edge (or on reset).
- Reset values: CARRY = 0, counter = 0, DONE = 0 when FRAME_LEN > 0 (since the counter is 0), registered Z = 0.
- With RESET_N low, Z = X ^ Y.

## Configuration
- SERIAL_ADDER_REGOUT_EN defined:
  - Z is registered (Moore style). Z at edge n+1 equals X^Y^C sampled at edge n, so latency is 1 cycle.
  - DONE is registered identically so it stays aligned with Z.
  - The reset value of registered Z and DONE is 0.
- SERIAL_ADDER_REGOUT_EN undefined: combinational Mealy Z and DONE as described in Timing.

## Structure
- Shared package serial_adder_pkg holds:
  - the state enum (S0, S1);
  - the counter width function clog2(FRAME_LEN);
  - the full-adder sum/carry functions.
- Sub-module full_adder_bit (inputs a, b, cin; outputs s, cout) is natural and is instantiated once. The carry flip-flop, frame counter and output register stay in the top level.

## Test plan
- Reset: hold RESET_N=0 for 12 ns with X=Y=1 -> CARRY=0, DONE=0. In combinational mode Z=0 (1^1); registered Z=0.
- Unframed sequence: after reset release, drive (X,Y) = 00, 10, 11, 01, 11, 00 on successive cycles.
  - Combinational Z = 0, 1, 0, 0, 1, 1.
  - CARRY after each edge = 0, 0, 1, 1, 1, 0.
- Registered mode with the same stream: Z lags by one cycle: 0, 0, 1, 0, 0, 1, 1.
- Framed operation, FRAME_LEN=4: stream 0xF + 0x1 LSB first (X=1111, Y=1000) -> Z=0000, DONE high on the 4th bit, carry cleared. The next frame 0x1 + 0x1 gives Z=0100 (value 0x2).
- Asynchronous reset mid-stream: force CARRY=1, then pulse RESET_N low for 3 ns between edges -> CARRY drops to 0 without waiting for a clock edge, and the counter returns to 0.
- Exhaustive check: all 8 combinations of X, Y and carry state, checking Z and next CARRY against the full-adder truth table.
